// File: rtl/uart_report_pkg.sv
// Shared definitions for the UART report formatter: FSM encoding, ASCII constants,
// frame layout lengths and small ASCII rendering helpers.
package uart_report_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSnap = 2'd1,
        StSend = 2'd2,
        StDone = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_COLON = 8'h3a;
    localparam logic [7:0] ASCII_COMMA = 8'h2c;
    localparam logic [7:0] ASCII_EQ    = 8'h3d;
    localparam logic [7:0] ASCII_STAR  = 8'h2a;
    localparam logic [7:0] ASCII_LF    = 8'h0a;
    localparam logic [7:0] ASCII_SP    = 8'h20;

    // "time HH:MM:SS" and ", cK=DDD"
    localparam int unsigned HDR_LEN = 13;
    localparam int unsigned CH_LEN  = 8;

    // Two ASCII decimal digits {tens, ones} of a 0..63 value.
    function automatic logic [15:0] dec2_ascii(input logic [5:0] v);
        return {ASCII_0 + 8'(v / 6'd10), ASCII_0 + 8'(v % 6'd10)};
    endfunction

    // One uppercase ASCII hex digit.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (ASCII_0 + {4'b0, n}) : (8'h37 + {4'b0, n});
    endfunction

endpackage

// File: rtl/uart_report_formatter_if.sv
// Byte-push interface towards the downstream TX FIFO.
interface uart_report_formatter_if;
    logic       tx_full;
    logic       tx_push;
    logic [7:0] tx_push_data;

    modport master (input tx_full, output tx_push, output tx_push_data);
    modport slave  (output tx_full, input tx_push, input tx_push_data);
endinterface

// File: rtl/uart_report_formatter_bin_to_dec3.sv
// Combinational binary to 3-digit zero-padded ASCII decimal, saturating at 999.
module bin_to_dec3
    import uart_report_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_val,
    output logic [7:0]   o_d2,
    output logic [7:0]   o_d1,
    output logic [7:0]   o_d0
);
    logic [31:0] w_val;
    logic [9:0]  w_sat;
    logic [9:0]  w_rem;

    // Saturate, then split into hundreds / tens / ones.
    always_comb begin
        w_val = 32'(i_val);
        w_sat = (w_val > 32'd999) ? 10'd999 : 10'(w_val);
        w_rem = w_sat % 10'd100;
        o_d2  = ASCII_0 + 8'(w_sat / 10'd100);
        o_d1  = ASCII_0 + 8'(w_rem / 10'd10);
        o_d0  = ASCII_0 + 8'(w_rem % 10'd10);
    end
endmodule

// File: rtl/uart_report_formatter.sv
// UART report formatter: snapshots time and sensor channels and pushes an ASCII frame
// "time HH:MM:SS, c0=DDD, ...\n" one byte per non-full cycle.
// Optional macro REPORT_CHECKSUM_EN appends "*HH" (XOR of the bytes before '*').
module uart_report_formatter
    import uart_report_pkg::*;
#(
    parameter int unsigned NUM_CH       = 2,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PERIOD_TICKS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     tick,
    input  logic                     auto_en,
    input  logic [5:0]               i_hour,
    input  logic [5:0]               i_min,
    input  logic [5:0]               i_sec,
    input  logic [NUM_CH*DATA_W-1:0] i_ch_data,
    uart_report_formatter_if.master  tx,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     overrun
);
    localparam int unsigned CH_END = HDR_LEN + CH_LEN * NUM_CH;
`ifdef REPORT_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = CH_END + 4;
`else
    localparam int unsigned FRAME_LEN = CH_END + 1;
`endif
    localparam logic [6:0] IDX_LAST = 7'(FRAME_LEN - 1);

    state_t                    r_state, w_state_d;
    logic [6:0]                r_idx;
    logic [7:0]                r_tick_cnt;
    logic                      r_pending, w_pending_d;
    logic                      r_overrun, w_overrun_d;
    logic [5:0]                r_hour, r_min, r_sec;
    logic [NUM_CH*DATA_W-1:0]  r_ch;
    logic                      w_auto_evt, w_req, w_push, w_last;
    logic [6:0]                w_off;
    logic [2:0]                w_ch_k, w_pos;
    logic [DATA_W-1:0]         w_ch_sel;
    logic [7:0]                w_d2, w_d1, w_d0, w_byte;
    logic [15:0]               w_hd, w_md, w_sd;
`ifdef REPORT_CHECKSUM_EN
    logic [7:0]                r_csum;
`endif

    assign w_auto_evt = auto_en & tick & (r_tick_cnt == 8'(PERIOD_TICKS - 1));
    // A coincident start and auto-tick collapse into one request.
    assign w_req      = start | w_auto_evt;

    // State and request bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= StIdle;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pending <= w_pending_d;
            r_overrun <= w_overrun_d;
        end
    end

    // Next-state, push strobe and pending/overrun handling.
    always_comb begin
        w_state_d   = r_state;
        w_pending_d = r_pending;
        w_overrun_d = r_overrun;
        w_push      = 1'b0;
        w_last      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_req || r_pending) begin
                    w_state_d   = StSnap;
                    // Serving a pending request while a new one arrives keeps one queued.
                    w_pending_d = r_pending & w_req;
                end
            end
            StSnap: w_state_d = StSend;
            StSend: begin
                w_push = ~tx.tx_full;
                w_last = w_push && (r_idx == IDX_LAST);
                if (w_last) begin
                    w_state_d = StDone;
                end
            end
            StDone: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
        if ((r_state != StIdle) && w_req) begin
            if (r_pending) begin
                w_overrun_d = 1'b1;
            end else begin
                w_pending_d = 1'b1;
            end
        end
    end

    // Auto-frame tick counter; cleared whenever auto mode is off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!auto_en) begin
            r_tick_cnt <= '0;
        end else if (tick) begin
            r_tick_cnt <= w_auto_evt ? 8'd0 : r_tick_cnt + 8'd1;
        end
    end

    // Input snapshot taken in SNAP; the frame is rendered only from these copies.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hour <= '0;
            r_min  <= '0;
            r_sec  <= '0;
            r_ch   <= '0;
        end else if (r_state == StSnap) begin
            r_hour <= i_hour;
            r_min  <= i_min;
            r_sec  <= i_sec;
            r_ch   <= i_ch_data;
        end
    end

    // Byte index advances only on an accepted push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx <= '0;
        end else if (r_state == StSnap) begin
            r_idx <= '0;
        end else if (w_push) begin
            r_idx <= w_last ? 7'd0 : r_idx + 7'd1;
        end
    end

`ifdef REPORT_CHECKSUM_EN
    // Running XOR of every byte pushed ahead of the '*'.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_csum <= '0;
        end else if (r_state == StSnap) begin
            r_csum <= '0;
        end else if (w_push && (r_idx < 7'(CH_END))) begin
            r_csum <= r_csum ^ w_byte;
        end
    end
`endif

    // Channel selection for the single shared decimal converter.
    always_comb begin
        w_off    = r_idx - 7'(HDR_LEN);
        w_ch_k   = 3'(w_off >> 3);
        w_pos    = w_off[2:0];
        w_ch_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_ch_k == 3'(k)) begin
                w_ch_sel = r_ch[k*DATA_W +: DATA_W];
            end
        end
    end

    bin_to_dec3 #(
        .W (DATA_W)
    ) u_bin_to_dec3 (
        .i_val (w_ch_sel),
        .o_d2  (w_d2),
        .o_d1  (w_d1),
        .o_d0  (w_d0)
    );

    assign w_hd = dec2_ascii(r_hour);
    assign w_md = dec2_ascii(r_min);
    assign w_sd = dec2_ascii(r_sec);

    // Frame byte for the current index.
    always_comb begin
        w_byte = ASCII_LF;
        if (r_idx < 7'(HDR_LEN)) begin
            case (r_idx)
                7'd0:    w_byte = "t";
                7'd1:    w_byte = "i";
                7'd2:    w_byte = "m";
                7'd3:    w_byte = "e";
                7'd4:    w_byte = ASCII_SP;
                7'd5:    w_byte = w_hd[15:8];
                7'd6:    w_byte = w_hd[7:0];
                7'd7:    w_byte = ASCII_COLON;
                7'd8:    w_byte = w_md[15:8];
                7'd9:    w_byte = w_md[7:0];
                7'd10:   w_byte = ASCII_COLON;
                7'd11:   w_byte = w_sd[15:8];
                default: w_byte = w_sd[7:0];
            endcase
        end else if (r_idx < 7'(CH_END)) begin
            case (w_pos)
                3'd0:    w_byte = ASCII_COMMA;
                3'd1:    w_byte = ASCII_SP;
                3'd2:    w_byte = "c";
                3'd3:    w_byte = ASCII_0 + 8'(w_ch_k);
                3'd4:    w_byte = ASCII_EQ;
                3'd5:    w_byte = w_d2;
                3'd6:    w_byte = w_d1;
                default: w_byte = w_d0;
            endcase
`ifdef REPORT_CHECKSUM_EN
        end else if (r_idx == 7'(CH_END)) begin
            w_byte = ASCII_STAR;
        end else if (r_idx == 7'(CH_END + 1)) begin
            w_byte = hex_ascii(r_csum[7:4]);
        end else if (r_idx == 7'(CH_END + 2)) begin
            w_byte = hex_ascii(r_csum[3:0]);
`endif
        end
    end

    assign tx.tx_push      = w_push;
    assign tx.tx_push_data = w_push ? w_byte : 8'h00;
    assign frame_done      = w_last;
    assign busy            = (r_state != StIdle);
    assign overrun         = r_overrun;
endmodule

// File: tb/tb_uart_report_formatter.sv
// Directed self-checking bench for uart_report_formatter (NUM_CH=2, DATA_W=12).
module tb_uart_report_formatter;
    localparam int unsigned NCH = 2;
    localparam int unsigned DW  = 12;
    localparam int unsigned PT  = 5;

    logic            clk = 1'b0;
    logic            reset, start, tick, auto_en;
    logic [5:0]      i_hour, i_min, i_sec;
    logic [NCH*DW-1:0] i_ch_data;
    logic            busy, frame_done, overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int push_cnt = 0, done_cnt = 0, push_full = 0, fd_nopush = 0;
    int last_done_cyc = 0;
    logic [7:0] last_done_byte = 8'h00;
    logic [7:0] rx_q[$];
    int start_q[$];
    bit in_frame = 1'b0;

    uart_report_formatter_if tx();

    uart_report_formatter #(
        .NUM_CH       (NCH),
        .DATA_W       (DW),
        .PERIOD_TICKS (PT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .tick       (tick),
        .auto_en    (auto_en),
        .i_hour     (i_hour),
        .i_min      (i_min),
        .i_sec      (i_sec),
        .i_ch_data  (i_ch_data),
        .tx         (tx.master),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Byte collector, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            in_frame = 1'b0;
        end else begin
            if (frame_done && !tx.tx_push) fd_nopush++;
            if (tx.tx_push) begin
                if (tx.tx_full) push_full++;
                if (!in_frame) begin
                    start_q.push_back(cyc);
                    in_frame = 1'b1;
                end
                rx_q.push_back(tx.tx_push_data);
                push_cnt++;
                if (frame_done) begin
                    in_frame       = 1'b0;
                    done_cnt++;
                    last_done_byte = tx.tx_push_data;
                    last_done_cyc  = cyc;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic set_in(input int h, input int m, input int s, input int c0, input int c1);
        i_hour    = 6'(h);
        i_min     = 6'(m);
        i_sec     = 6'(s);
        i_ch_data = {12'(c1), 12'(c0)};
    endtask

    task automatic wait_done(input string tag, input int n, input int budget);
        int k = 0;
        while (done_cnt < n && k < budget) begin
            step(1);
            k++;
        end
        chk(tag, 32'(done_cnt >= n), 32'd1);
    endtask

    function automatic int sat(input int v);
        return (v > 999) ? 999 : v;
    endfunction

    function automatic string mk_frame(input int h, input int m, input int s,
                                       input int c0, input int c1);
        string f;
        int cs;
        f = $sformatf("time %02d:%02d:%02d, c0=%03d, c1=%03d", h, m, s, sat(c0), sat(c1));
`ifdef REPORT_CHECKSUM_EN
        cs = 0;
        for (int i = 0; i < f.len(); i++) cs = cs ^ int'(f[i]);
        f = {f, $sformatf("*%02X", cs)};
`else
        cs = 0;
`endif
        return {f, "\n"};
    endfunction

    task automatic check_frame(input string tag, input string exp);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp.len()));
        for (int i = 0; i < exp.len() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_b%0d", tag, i), 32'(rx_q[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        string exp;
        int d0, s0, k, pc;
        int tcyc[12];

        reset = 1'b1; start = 1'b0; tick = 1'b0; auto_en = 1'b0;
        tx.tx_full = 1'b0;
        set_in(0, 0, 0, 0, 0);

        // Reset state
        step(3);
        @(negedge clk);
        chk("rst_push", 32'(tx.tx_push), 32'd0);
        chk("rst_data", 32'(tx.tx_push_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        step(1);
        reset = 1'b0;
        step(2);

        // Basic frame, inputs changed after snapshot must not leak in
        set_in(7, 5, 9, 25, 60);
        rx_q.delete();
        k = cyc;
        pulse_start();
        chk("a_busy", 32'(busy), 32'd1);
        step(1);
        set_in(23, 59, 58, 777, 888);
        wait_done("a_timeout", 1, 100);
        exp = mk_frame(7, 5, 9, 25, 60);
        check_frame("a", exp);
        chk("a_latency_ge2", 32'((start_q[0] - k) >= 2), 32'd1);
        chk("a_consecutive", 32'(last_done_cyc - start_q[0]), 32'(exp.len() - 1));
        chk("a_done_lf", 32'(last_done_byte), 32'h0a);
        step(3);
        chk("a_idle", 32'(busy), 32'd0);

        // Back-pressure after byte 3, boundary time/channel values
        set_in(63, 0, 59, 0, 1000);
        rx_q.delete();
        pulse_start();
        k = 0;
        while (rx_q.size() < 3 && k < 100) begin
            step(1);
            k++;
        end
        tx.tx_full = 1'b1;
        step(4);
        chk("b_hold_cnt", 32'(rx_q.size()), 32'd3);
        tx.tx_full = 1'b0;
        wait_done("b_timeout", 2, 100);
        check_frame("b", mk_frame(63, 0, 59, 0, 1000));
        chk("b_push_full", 32'(push_full), 32'd0);
        step(3);

        // Auto mode: 12 ticks -> frames after ticks 5 and 10
        d0 = done_cnt;
        s0 = start_q.size();
        auto_en = 1'b1;
        step(1);
        for (int i = 0; i < 12; i++) begin
            tick = 1'b1;
            tcyc[i] = cyc;
            step(1);
            tick = 1'b0;
            step(45);
        end
        chk("c_frames", 32'(done_cnt - d0), 32'd2);
        chk("c_starts", 32'(start_q.size() - s0), 32'd2);
        if (start_q.size() >= s0 + 2) begin
            chk("c_start1_win", 32'(start_q[s0] > tcyc[4] && start_q[s0] < tcyc[5]), 32'd1);
            chk("c_start2_win",
                32'(start_q[s0+1] > tcyc[9] && start_q[s0+1] < tcyc[10]), 32'd1);
        end
        auto_en = 1'b0;
        step(2);

        // Start coinciding with the auto-tick event is a single request
        d0 = done_cnt;
        auto_en = 1'b1;
        step(1);
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(2);
        end
        chk("e_no_early", 32'(done_cnt - d0), 32'd0);
        tick = 1'b1;
        start = 1'b1;
        step(1);
        tick = 1'b0;
        start = 1'b0;
        auto_en = 1'b0;
        step(100);
        chk("e_one_frame", 32'(done_cnt - d0), 32'd1);
        chk("e_no_ovr", 32'(overrun), 32'd0);

        // Pending request and overrun
        d0 = done_cnt;
        set_in(1, 2, 3, 4, 5);
        pulse_start();
        step(5);
        pulse_start();
        chk("d_ovr_after_2", 32'(overrun), 32'd0);
        chk("d_busy", 32'(busy), 32'd1);
        step(5);
        pulse_start();
        chk("d_ovr_after_3", 32'(overrun), 32'd1);
        wait_done("d_timeout", d0 + 2, 200);
        step(80);
        chk("d_two_frames", 32'(done_cnt - d0), 32'd2);
        chk("d_ovr_sticky", 32'(overrun), 32'd1);

        // Reset in mid-frame, then a clean frame with a saturated channel
        set_in(10, 20, 30, 4095, 999);
        rx_q.delete();
        pulse_start();
        k = 0;
        while (rx_q.size() < 10 && k < 100) begin
            step(1);
            k++;
        end
        reset = 1'b1;
        @(negedge clk);
        chk("r_push", 32'(tx.tx_push), 32'd0);
        chk("r_busy", 32'(busy), 32'd0);
        chk("r_ovr", 32'(overrun), 32'd0);
        step(2);
        reset = 1'b0;
        pc = push_cnt;
        step(40);
        chk("r_no_push", 32'(push_cnt), 32'(pc));
        d0 = done_cnt;
        rx_q.delete();
        pulse_start();
        wait_done("r_timeout", d0 + 1, 100);
        check_frame("r", mk_frame(10, 20, 30, 4095, 999));
        chk("fd_without_push", 32'(fd_nopush), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_report_formatter.md
UART_REPORT_FORMATTER -- requirements
Module: uart_report_formatter

Interface
REQ-001 Parameter NUM_CH, default 2: number of sensor channels in a frame, legal range 1..8.
REQ-002 Parameter DATA_W, default 8: width of each sensor channel, legal range 1..16.
REQ-003 Parameter PERIOD_TICKS, default 5: number of tick pulses between automatic frames, legal range 1..255.
REQ-004 Port: clk  in  1  system clock; reset  in  1  reset, asynchronous, active-high.
REQ-005 Port: start  in  1  single-cycle manual frame request.
REQ-006 Port: tick  in  1  single-cycle time-base pulse, 1 Hz in system use.
REQ-007 Port: auto_en  in  1  when high, periodic frames are enabled.
REQ-008 Port: i_hour, i_min, i_sec  in  6 each  clock time, binary.
REQ-009 Port: i_ch_data  in  NUM_CH*DATA_W  channel values; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-010 Port: tx_full  in  1  downstream TX FIFO full.
REQ-011 Port: tx_push  out  1  one-cycle byte write strobe.
REQ-012 Port: tx_push_data  out  8  ASCII byte, valid only while tx_push is high.
REQ-013 Port: busy  out  1  high from the snapshot cycle until the frame completes.
REQ-014 Port: frame_done  out  1  one-cycle pulse when the last byte of a frame is pushed.
REQ-015 Port: overrun  out  1  sticky flag set when a request is dropped; cleared only by reset.

Function
REQ-016 Frame format: "time HH:MM:SS"; then, for each channel k = 0..NUM_CH-1, ", c<k>=DDD"; then "\n".
REQ-017 Frame length: 14 + 8*NUM_CH bytes without the checksum option, and 3 bytes more with it.
REQ-018 Time fields are rendered as 2 decimal digits each; values above 59 are rendered as-is (max 63 -> "63").
REQ-019 Channel values are rendered as 3 zero-padded decimal digits; values above 999 saturate to "999".
REQ-020 FSM states: IDLE, SNAP, SEND, DONE.
  - IDLE -> SNAP on a request.
  - SNAP -> SEND after 1 cycle.
  - SEND -> DONE after the last byte is pushed.
  - DONE -> IDLE after 1 cycle.
REQ-021 In SNAP, all time and channel inputs are latched; the frame content SHALL use only the latched values.
REQ-022 A request is a start pulse, or an auto-tick event (auto_en high and the tick counter reaching PERIOD_TICKS).
REQ-023 On an auto-tick event the tick counter SHALL reload to 0; the counter holds at 0 while auto_en is low.
REQ-024 In SEND, exactly one byte is pushed per cycle in which tx_full is low; tx_push stays low while tx_full is high, and the byte index holds.
REQ-025 The first tx_push occurs no earlier than 2 cycles after the request cycle.
REQ-026 A request arriving while busy sets a single pending bit, which is serviced in the cycle DONE returns to IDLE.
REQ-027 A request arriving while pending is already set SHALL be dropped and SHALL set overrun.
REQ-028 A start and an auto-tick event in the same cycle count as one request.
REQ-029 frame_done SHALL coincide with the tx_push of the final "\n".

Reset
REQ-030 During reset:
  - state = IDLE;
  - tx_push = 0; tx_push_data = 0x00;
  - busy = 0; frame_done = 0; overrun = 0;
  - pending = 0; tick counter = 0; byte index = 0.
REQ-031 A reset asserted mid-frame SHALL abort the frame immediately, with no further pushes after deassertion until a new request.

Configuration
REQ-032 Macro REPORT_CHECKSUM_EN:
  - When defined, "*" plus 2 uppercase hex digits are inserted before "\n".
  - The checksum is the XOR of all preceding frame bytes, starting with "t".
  - When undefined, no checksum logic is present and the frame is as in REQ-016.

Structure
REQ-033 A shared package uart_report_pkg SHALL hold:
  - the FSM state encoding;
  - ASCII constants (0x30 digit base, ':', ',', '=', '*', '\n');
  - the header length (13) and per-channel length (8).
REQ-034 One sub-module, bin_to_dec3 (combinational saturating binary-to-3-digit-ASCII converter), SHALL be instantiated once and muxed by channel index.

Verification
REQ-035 Defaults, time 07:05:09, ch0=25, ch1=60, tx_full=0, start pulse -> 30 bytes "time 07:05:09, c0=025, c1=060\n" on consecutive cycles, frame_done on the "\n".
REQ-036 tx_full high for 4 cycles after byte 3 -> no push while full, byte sequence intact, total length 30.
REQ-037 auto_en=1, PERIOD_TICKS=5, 12 ticks -> exactly 2 frames, starting after tick 5 and tick 10.
REQ-038 start during a frame, then start again -> second frame follows the first; third request dropped; overrun=1.
REQ-039 DATA_W=12, ch0=4095 -> "c0=999"; with REPORT_CHECKSUM_EN defined -> "*" plus the correct XOR hex before "\n", length 33.
REQ-040 reset asserted at byte 10 -> tx_push=0 and busy=0 on the next cycle; a new start produces a complete frame.
